// File: rtl/baud_cfg_pkg.sv
// Shared types and constants for the SPART baud divisor configuration path.
// Bus register addresses, FSM state encoding, default divisor width.
package baud_cfg_pkg;

  localparam int DIV_W_DEF = 16;

  localparam logic [1:0] ADDR_DBL = 2'b10;
  localparam logic [1:0] ADDR_DBH = 2'b11;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WAIT_HI,
    PEND,
    LOAD
  } state_t;

endpackage

// File: rtl/baud_defer_timer.sv
// Saturating defer counter; flags expiry once it has waited MAX_DEFER-1 cycles.
// Clear has priority over enable.
module baud_defer_timer #(
  parameter int MAX_DEFER = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (MAX_DEFER > 2) ? $clog2(MAX_DEFER) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_DEFER - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/baud_cfg_ctrl.sv
// Baud divisor configuration sequencer: shadows DBL/DBH writes and commits
// them to the baud generator only when the link is idle or the wait times out.
module baud_cfg_ctrl
  import baud_cfg_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter logic [DIV_W-1:0] RESET_DIV = DIV_W'(162),
  parameter int MAX_DEFER = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iocs,
  input  logic             iorw,
  input  logic [1:0]       ioaddr,
  input  logic [7:0]       data_in,
  input  logic             tx_busy,
  input  logic             rx_busy,
  output logic             brg_wr_en,
  output logic [DIV_W-1:0] brg_div,
  output logic             cfg_busy,
  output logic [7:0]       rd_data,
  output logic             rd_valid
);

  state_t state;
  state_t nxt;

  logic [7:0]       lo_shadow;
  logic [DIV_W-1:0] cand;
  logic [DIV_W-1:0] raw_div;
  logic [DIV_W-1:0] new_div;

  logic wr_lo;
  logic wr_hi;
  logic rd_hit;
  logic upd_lo;
  logic upd_cand;
  logic link_busy;
  logic t_clr;
  logic t_en;
  logic t_exp;

  assign wr_lo     = iocs & ~iorw & (ioaddr == ADDR_DBL);
  assign wr_hi     = iocs & ~iorw & (ioaddr == ADDR_DBH);
  assign rd_hit    = iocs & iorw & ioaddr[1];
  assign link_busy = tx_busy | rx_busy;

  // The generator must never be loaded with zero.
  assign raw_div = DIV_W'({data_in, lo_shadow});
  assign new_div = (raw_div == '0) ? DIV_W'(1) : raw_div;

  always_comb begin
    nxt      = state;
    upd_lo   = 1'b0;
    upd_cand = 1'b0;
    unique case (state)
      INIT: nxt = LOAD;
      IDLE, LOAD: begin
        nxt = IDLE;
        if (wr_lo) begin
          upd_lo = 1'b1;
          nxt    = WAIT_HI;
        end else if (wr_hi) begin
          upd_cand = 1'b1;
          nxt      = PEND;
        end
      end
      WAIT_HI: begin
        if (wr_lo) begin
          upd_lo = 1'b1;
        end else if (wr_hi) begin
          upd_cand = 1'b1;
          nxt      = PEND;
        end
      end
      PEND: begin
        if (wr_lo) begin
          upd_lo = 1'b1;
          nxt    = WAIT_HI;
        end else if (wr_hi) begin
          upd_cand = 1'b1;
        end else if (!link_busy || t_exp) begin
          nxt = LOAD;
        end
      end
      default: nxt = INIT;
    endcase
  end

  assign t_clr = (nxt == LOAD) || (nxt == WAIT_HI);
  assign t_en  = (state == PEND) && link_busy;

  baud_defer_timer #(
    .MAX_DEFER(MAX_DEFER)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (t_clr),
    .en     (t_en),
    .expired(t_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INIT;
      brg_wr_en <= 1'b0;
      brg_div   <= RESET_DIV;
      cfg_busy  <= 1'b1;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      lo_shadow <= '0;
      cand      <= RESET_DIV;
    end else begin
      state     <= nxt;
      brg_wr_en <= (nxt == LOAD);
      cfg_busy  <= (nxt == INIT) || (nxt == PEND) || (nxt == LOAD);
      rd_valid  <= rd_hit;
      if (nxt == LOAD) brg_div <= cand;
      if (upd_lo) lo_shadow <= data_in;
      if (upd_cand) cand <= new_div;
      if (rd_hit) rd_data <= ioaddr[0] ? brg_div[15:8] : brg_div[7:0];
    end
  end

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// Randomized and directed checks of baud_cfg_ctrl against a transaction-level
// model of pending divisor commits.
module tb_baud_cfg_ctrl;

  localparam int MAXD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iocs = 1'b0;
  logic        iorw = 1'b0;
  logic [1:0]  ioaddr = 2'b00;
  logic [7:0]  data_in = 8'h00;
  logic        tx_busy = 1'b0;
  logic        rx_busy = 1'b0;
  logic        brg_wr_en;
  logic [15:0] brg_div;
  logic        cfg_busy;
  logic [7:0]  rd_data;
  logic        rd_valid;

  int n_vec = 0;
  int n_err = 0;
  int n_stb = 0;

  // model state
  logic [15:0] m_div, m_cand;
  logic [7:0]  m_lo, m_rdd;
  bit          m_pend, m_boot, m_stb, m_busy, m_rdv;
  int          m_wait;

  always #5 clk = ~clk;

  baud_cfg_ctrl #(
    .DIV_W(16),
    .RESET_DIV(16'd162),
    .MAX_DEFER(MAXD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .iocs(iocs),
    .iorw(iorw),
    .ioaddr(ioaddr),
    .data_in(data_in),
    .tx_busy(tx_busy),
    .rx_busy(rx_busy),
    .brg_wr_en(brg_wr_en),
    .brg_div(brg_div),
    .cfg_busy(cfg_busy),
    .rd_data(rd_data),
    .rd_valid(rd_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_div  = 16'd162;
    m_cand = 16'd162;
    m_lo   = 8'h00;
    m_rdd  = 8'h00;
    m_pend = 0;
    m_boot = 1;
    m_stb  = 0;
    m_busy = 1;
    m_rdv  = 0;
    m_wait = 0;
  endtask

  // One clock of the model: a commit waits while the link is busy, but no
  // longer than MAXD-1 busy cycles; bus writes take precedence over a commit.
  task automatic model_step(input logic cs, input logic rw,
                            input logic [1:0] a, input logic [7:0] d,
                            input logic busy);
    bit wr, ld, was_p;
    logic [15:0] v;
    wr    = cs && !rw;
    was_p = m_pend;
    ld    = 0;
    m_rdv = cs && rw && a[1];
    if (m_rdv) m_rdd = a[0] ? m_div[15:8] : m_div[7:0];
    if (m_boot) begin
      m_boot = 0;
      ld = 1;
    end else if (wr && a == 2'b10) begin
      m_lo   = d;
      m_pend = 0;
      m_wait = 0;
    end else if (wr && a == 2'b11) begin
      v = {d, m_lo};
      m_cand = (v == 16'd0) ? 16'd1 : v;
      if (!was_p) m_wait = 0;
      else if (busy && m_wait < MAXD - 1) m_wait++;
      m_pend = 1;
    end else if (m_pend) begin
      if (!busy || m_wait == MAXD - 1) begin
        m_pend = 0;
        ld = 1;
      end else begin
        m_wait++;
      end
    end
    m_stb = ld;
    if (ld) begin
      m_div  = m_cand;
      m_wait = 0;
    end
    m_busy = m_pend || ld;
  endtask

  // Entered and left at a negedge: drive, clock, model, compare.
  task automatic cycle(input logic cs, input logic rw, input logic [1:0] a,
                       input logic [7:0] d, input logic tb, input logic rb);
    iocs = cs; iorw = rw; ioaddr = a; data_in = d;
    tx_busy = tb; rx_busy = rb;
    @(posedge clk);
    model_step(cs, rw, a, d, tb || rb);
    #1;
    if (brg_wr_en === 1'b1) n_stb++;
    chk("wr_en", 32'(brg_wr_en), 32'(m_stb));
    chk("div", 32'(brg_div), 32'(m_div));
    chk("cfg_busy", 32'(cfg_busy), 32'(m_busy));
    chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
    chk("rd_data", 32'(rd_data), 32'(m_rdd));
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic tb, input logic rb);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'b00, 8'h00, tb, rb);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    iocs = 1'b0;
    #1;
    chk("rst_wr_en", 32'(brg_wr_en), 32'd0);
    chk("rst_div", 32'(brg_div), 32'd162);
    chk("rst_busy", 32'(cfg_busy), 32'd1);
    chk("rst_rdv", 32'(rd_valid), 32'd0);
    chk("rst_rdd", 32'(rd_data), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int first;
    logic tbv, rbv;
    model_reset();
    @(negedge clk);
    do_reset();

    // post-reset auto-load in the second cycle
    chk("boot_pre", 32'(brg_wr_en), 32'd0);
    idle(1, 1'b0, 1'b0);
    chk("boot_stb", 32'(brg_wr_en), 32'd1);
    chk("boot_div", 32'(brg_div), 32'd162);
    idle(1, 1'b0, 1'b0);
    chk("boot_idle", 32'(cfg_busy), 32'd0);

    // plain commit: strobe two cycles after DBH
    cycle(1'b1, 1'b0, 2'b10, 8'h45, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 2'b11, 8'h01, 1'b0, 1'b0);
    chk("lat_n1", 32'(brg_wr_en), 32'd0);
    idle(1, 1'b0, 1'b0);
    chk("lat_n2", 32'(brg_wr_en), 32'd1);
    chk("div_0145", 32'(brg_div), 32'h0145);
    cycle(1'b1, 1'b1, 2'b11, 8'h00, 1'b0, 1'b0);
    chk("rd_dbh", 32'(rd_data), 32'h01);
    cycle(1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0);
    chk("rd_dbl", 32'(rd_data), 32'h45);
    cycle(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
    chk("rd_01", 32'(rd_valid), 32'd0);

    // deferred by tx_busy, released when it drops
    cycle(1'b1, 1'b0, 2'b10, 8'h10, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 2'b11, 8'h00, 1'b1, 1'b0);
    n_stb = 0;
    idle(5, 1'b1, 1'b0);
    chk("tx_hold", 32'(n_stb), 32'd0);
    idle(1, 1'b0, 1'b0);
    chk("tx_rel", 32'(brg_wr_en), 32'd1);
    chk("div_0010", 32'(brg_div), 32'h0010);

    // forced commit while rx_busy never drops
    cycle(1'b1, 1'b0, 2'b10, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 2'b11, 8'h02, 1'b0, 1'b1);
    first = -1;
    for (int k = 1; k <= 20 && first < 0; k++) begin
      idle(1, 1'b0, 1'b1);
      if (brg_wr_en === 1'b1) first = k;
    end
    chk("force_lat", 32'(first), 32'(MAXD));
    chk("div_0200", 32'(brg_div), 32'h0200);
    idle(2, 1'b0, 1'b1);

    // zero divisor is coerced to 1
    cycle(1'b1, 1'b0, 2'b10, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b0);
    chk("div_zero", 32'(brg_div), 32'h0001);

    // DBL during pending commit cancels it
    cycle(1'b1, 1'b0, 2'b10, 8'h33, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 2'b11, 8'h44, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 2'b10, 8'h55, 1'b1, 1'b0);
    chk("cancel_busy", 32'(cfg_busy), 32'd0);
    n_stb = 0;
    idle(12, 1'b0, 1'b0);
    chk("cancel_stb", 32'(n_stb), 32'd0);
    chk("cancel_div", 32'(brg_div), 32'h0001);

    // reset during a pending commit discards it
    cycle(1'b1, 1'b0, 2'b10, 8'h77, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 2'b11, 8'h66, 1'b1, 1'b0);
    do_reset();
    idle(1, 1'b0, 1'b0);
    chk("rerst_stb", 32'(brg_wr_en), 32'd1);
    chk("rerst_div", 32'(brg_div), 32'd162);
    n_stb = 0;
    idle(12, 1'b0, 1'b0);
    chk("rerst_quiet", 32'(n_stb), 32'd0);

    // random traffic against the model
    tbv = 1'b0;
    rbv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      if ($urandom_range(0, 7) == 0) tbv = ~tbv;
      if ($urandom_range(0, 11) == 0) rbv = ~rbv;
      d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      cycle($urandom_range(0, 3) == 0, 1'($urandom), 2'($urandom), d,
            tbv, rbv);
      if (i % 1000 == 999) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
